// File: rtl/sync_ram_dp.sv
// ============================================================================
//  Module   : sync_ram_dp
//  Brief    : Simple dual-port synchronous RAM with byte enables, write-first
//             bypass, optional output register and post-reset zero-fill.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ram_dp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int OUT_REG = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                init_done
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_done_q, init_done_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_wr;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NBYTES-1:0]   mem_wbe;

    logic                rd_fire;
    logic [DATA_W-1:0]   rd_merged;
    logic [DATA_W-1:0]   rdata_s1_q, rdata_s1_d;
    logic                rvalid_s1_q, rvalid_s1_d;

    // The clear sequencer owns the write port until the array is zeroed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        mem_wr      = 1'b0;
        mem_waddr   = waddr;
        mem_wdata   = wdata;
        mem_wbe     = wbe;
        case (state_q)
            ST_CLEAR: begin
                mem_wr    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                mem_wbe   = '1;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            ST_READY: begin
                mem_wr = we;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (mem_wbe[i]) begin
                    mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Write-first bypass: enabled bytes of a same-address write override the array.
    always_comb begin
        rd_fire   = (state_q == ST_READY) && re;
        rd_merged = mem_q[raddr];
        for (int i = 0; i < NBYTES; i++) begin
            if ((state_q == ST_READY) && we && (waddr == raddr) && wbe[i]) begin
                rd_merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        rvalid_s1_d = rd_fire;
        rdata_s1_d  = rd_fire ? rd_merged : rdata_s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_s1_q  <= '0;
            rvalid_s1_q <= 1'b0;
        end else begin
            rdata_s1_q  <= rdata_s1_d;
            rvalid_s1_q <= rvalid_s1_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rdata_s2_q, rdata_s2_d;
            logic              rvalid_s2_q, rvalid_s2_d;

            always_comb begin
                rvalid_s2_d = rvalid_s1_q;
                rdata_s2_d  = rvalid_s1_q ? rdata_s1_q : rdata_s2_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_s2_q  <= '0;
                    rvalid_s2_q <= 1'b0;
                end else begin
                    rdata_s2_q  <= rdata_s2_d;
                    rvalid_s2_q <= rvalid_s2_d;
                end
            end

            assign rdata  = rdata_s2_q;
            assign rvalid = rvalid_s2_q;
        end else begin : g_no_out_reg
            assign rdata  = rdata_s1_q;
            assign rvalid = rvalid_s1_q;
        end
    endgenerate

    assign init_done = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_ram_dp.sv
// ============================================================================
//  Module   : tb_sync_ram_dp
//  Brief    : Self-checking bench for sync_ram_dp, both output-latency builds.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_ram_dp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic        re = 1'b0;
    logic [3:0]  raddr = '0;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, init0, init1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: array contents, clear progress and expected outputs.
    logic [31:0] mem_m [16];
    int          clr_m = 0;
    logic        ev0 = 1'b0, ev1 = 1'b0;
    logic [31:0] ed0 = '0, ed1 = '0;

    always #5 clk = ~clk;

    sync_ram_dp #(.DATA_W(32), .ADDR_W(4), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .init_done(init0)
    );

    sync_ram_dp #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .init_done(init1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_init;
        exp_init = (clr_m >= 16) ? 32'd1 : 32'd0;
        check("rvalid0", {31'd0, rvalid0}, {31'd0, ev0});
        check("rdata0",  rdata0, ed0);
        check("rvalid1", {31'd0, rvalid1}, {31'd0, ev1});
        check("rdata1",  rdata1, ed1);
        check("init0",   {31'd0, init0}, exp_init);
        check("init1",   {31'd0, init1}, exp_init);
    endtask

    task automatic model_reset();
        clr_m = 0;
        ev0 = 1'b0; ev1 = 1'b0;
        ed0 = '0;   ed1 = '0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic step();
        logic        nv0;
        logic [31:0] nd0, rd;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            nv0 = 1'b0;
            nd0 = ed0;
            if (clr_m < 16) begin
                clr_m++;
                if (clr_m == 16) begin
                    for (int k = 0; k < 16; k++) mem_m[k] = '0;
                end
            end else begin
                if (re) begin
                    rd = mem_m[raddr];
                    if (we && waddr == raddr) begin
                        for (int b = 0; b < 4; b++)
                            if (wbe[b]) rd[8*b +: 8] = wdata[8*b +: 8];
                    end
                    nv0 = 1'b1;
                    nd0 = rd;
                end
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (wbe[b]) mem_m[waddr][8*b +: 8] = wdata[8*b +: 8];
                end
            end
            ev1 = ev0;
            if (ev0) ed1 = ed0;
            ev0 = nv0;
            ed0 = nd0;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_init(input string tag);
        int edges;
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (init0) begin
                edges = k;
                break;
            end
        end
        check(tag, 32'(edges), 32'd16);
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; waddr = a; wdata = d; wbe = be; re = 1'b0;
        step();
        we = 1'b0;
    endtask

    initial begin
        // Clear sequence with a read held pending throughout
        re = 1'b1; raddr = 4'd0;
        do_reset();
        wait_init("init_edges");
        for (int a = 0; a < 16; a++) begin
            raddr = 4'(a);
            step();
            check("clear_rd", rdata0, 32'h0);
        end
        re = 1'b0;
        step();
        step();

        // Full write then read: latency 1 and 2
        write(4'd3, 32'hDEADBEEF, 4'hF);
        re = 1'b1; raddr = 4'd3;
        step();
        re = 1'b0;
        check("full_rd0", rdata0, 32'hDEADBEEF);
        check("full_v1_early", {31'd0, rvalid1}, 32'd0);
        step();
        check("full_rd1", rdata1, 32'hDEADBEEF);
        check("full_v1", {31'd0, rvalid1}, 32'd1);

        // Partial write
        write(4'd3, 32'h11223344, 4'b0101);
        re = 1'b1; raddr = 4'd3;
        step();
        re = 1'b0;
        check("part_rd0", rdata0, 32'hDE22BE44);
        step();

        // Read-during-write, same address, merged per byte
        write(4'd5, 32'h01020304, 4'hF);
        we = 1'b1; waddr = 4'd5; wdata = 32'hAABBCCDD; wbe = 4'b0011;
        re = 1'b1; raddr = 4'd5;
        step();
        we = 1'b0; re = 1'b0;
        check("rdw_rd0", rdata0, 32'h0102CCDD);
        step();
        check("rdw_rd1", rdata1, 32'h0102CCDD);

        // Back-to-back streaming reads
        for (int a = 0; a < 16; a++) write(4'(a), 32'(a) * 32'h01010101, 4'hF);
        re = 1'b1;
        for (int a = 0; a < 16; a++) begin
            raddr = 4'(a);
            step();
            check("stream_rd0", rdata0, 32'(a) * 32'h01010101);
        end
        re = 1'b0;
        step();
        step();

        // Reset pulse in the middle of the clear sequence
        do_reset();
        for (int k = 0; k < 7; k++) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midclr_init", {31'd0, init0}, 32'd0);
        step();
        rst_n = 1'b1;
        wait_init("reinit_edges");

        // Randomised traffic with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                we = 1'b0;
                re = 1'b1;
                do_reset();
            end
            we    = 1'($urandom_range(0, 1));
            waddr = 4'($urandom_range(0, 15));
            wdata = $urandom;
            wbe   = 4'($urandom_range(0, 15));
            re    = 1'($urandom_range(0, 1));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            step();
        end
        we = 1'b0; re = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
